// File: rtl/ber_monitor.sv
// Bit/frame error-rate monitor: queues transmitted words in a small reference FIFO,
// compares each decoded word against the oldest queued word and accumulates error statistics.
module ber_monitor #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tx_valid,
    input  logic [DATA_W-1:0]            tx_data,
    input  logic                         rx_valid,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         clear,
    output logic [CNT_W-1:0]             frame_cnt,
    output logic [CNT_W-1:0]             bit_err_cnt,
    output logic [CNT_W-1:0]             frame_err_cnt,
    output logic [$clog2(DATA_W+1)-1:0]  last_err_bits,
    output logic                         err_pulse,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = $clog2(DATA_W + 1);
    localparam int SW = ((CNT_W > EW) ? CNT_W : EW) + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [CNT_W-1:0]  r_frame_cnt, r_bit_err_cnt, r_frame_err_cnt;
    logic [EW-1:0]     r_last_err_bits;
    logic              r_err_pulse, r_overflow, r_underflow;

    logic              w_full, w_empty, w_pop, w_push, w_has_err;
    logic [DATA_W-1:0] w_diff;
    logic [EW-1:0]     w_err_bits;

    // Adds with one spare bit; any carry out of CNT_W bits clamps to all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [EW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return (s[SW-1:CNT_W] != '0) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign w_pop   = rx_valid && !w_empty;
    assign w_push  = tx_valid && (!w_full || w_pop);
    assign w_diff  = rx_data ^ r_mem[r_rd_ptr];

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_err_bits = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_err_bits = w_err_bits + EW'(w_diff[i]);
        end
    end

    assign w_has_err = (w_err_bits != '0);

    // NOTE: FIFO storage is deliberately not reset; the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
            r_frame_cnt     <= '0;
            r_bit_err_cnt   <= '0;
            r_frame_err_cnt <= '0;
            r_last_err_bits <= '0;
            r_err_pulse     <= 1'b0;
            r_overflow      <= 1'b0;
            r_underflow     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if (clear) begin
                r_frame_cnt     <= '0;
                r_bit_err_cnt   <= '0;
                r_frame_err_cnt <= '0;
                r_last_err_bits <= '0;
                r_err_pulse     <= 1'b0;
                r_overflow      <= 1'b0;
                r_underflow     <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_frame_cnt     <= sat_add(r_frame_cnt, EW'(1));
                    r_bit_err_cnt   <= sat_add(r_bit_err_cnt, w_err_bits);
                    r_frame_err_cnt <= sat_add(r_frame_err_cnt, EW'(w_has_err));
                    r_last_err_bits <= w_err_bits;
                    r_err_pulse     <= w_has_err;
                end else begin
                    r_err_pulse     <= 1'b0;
                end
                if (tx_valid && w_full && !w_pop) r_overflow  <= 1'b1;
                if (rx_valid && w_empty)          r_underflow <= 1'b1;
            end
        end
    end

    assign frame_cnt     = r_frame_cnt;
    assign bit_err_cnt   = r_bit_err_cnt;
    assign frame_err_cnt = r_frame_err_cnt;
    assign last_err_bits = r_last_err_bits;
    assign err_pulse     = r_err_pulse;
    assign fifo_level    = r_level;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;
endmodule

// File: tb/tb_ber_monitor.sv
// Self-checking bench for ber_monitor: directed test-plan sequences plus randomized traffic,
// scored against a queue-based reference model; a second instance with 4-bit counters covers saturation.
module tb_ber_monitor;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam longint unsigned MAX32 = 64'hFFFF_FFFF;
    localparam longint unsigned MAX4  = 64'd15;

    logic              clk;
    logic              rst, tx_valid, rx_valid, clear;
    logic [DATA_W-1:0] tx_data, rx_data;

    logic [31:0] frame_cnt, bit_err_cnt, frame_err_cnt;
    logic [4:0]  last_err_bits;
    logic        err_pulse, overflow, underflow;
    logic [2:0]  fifo_level;

    logic [3:0]  s_frame_cnt, s_bit_err_cnt, s_frame_err_cnt;
    logic [4:0]  s_last_err_bits;
    logic        s_err_pulse, s_overflow, s_underflow;
    logic [2:0]  s_fifo_level;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    longint unsigned m_frames, m_bits, m_ferr, m_frames4, m_bits4, m_ferr4;
    int unsigned     m_last;
    bit              m_pulse, m_ovf, m_udf;

    ber_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .clear(clear),
        .frame_cnt(frame_cnt), .bit_err_cnt(bit_err_cnt), .frame_err_cnt(frame_err_cnt),
        .last_err_bits(last_err_bits), .err_pulse(err_pulse), .fifo_level(fifo_level),
        .overflow(overflow), .underflow(underflow)
    );

    ber_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .clear(clear),
        .frame_cnt(s_frame_cnt), .bit_err_cnt(s_bit_err_cnt), .frame_err_cnt(s_frame_err_cnt),
        .last_err_bits(s_last_err_bits), .err_pulse(s_err_pulse), .fifo_level(s_fifo_level),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned v, input longint unsigned max);
        return (v > max) ? max : v;
    endfunction

    // Applies the specification's rules to one clock edge.
    task automatic model_edge();
        bit pop, push, full, was_empty;
        int unsigned w;
        if (rst) begin
            q.delete();
            m_frames = 0; m_bits = 0; m_ferr = 0;
            m_frames4 = 0; m_bits4 = 0; m_ferr4 = 0;
            m_last = 0; m_pulse = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        was_empty = (q.size() == 0);
        full      = (q.size() == DEPTH);
        pop       = rx_valid && !was_empty;
        push      = tx_valid && (!full || pop);
        w         = pop ? $countones(rx_data ^ q[0]) : 0;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(tx_data);
        if (clear) begin
            m_frames = 0; m_bits = 0; m_ferr = 0;
            m_frames4 = 0; m_bits4 = 0; m_ferr4 = 0;
            m_last = 0; m_pulse = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (pop) begin
                m_frames  = sat(m_frames + 1, MAX32);
                m_bits    = sat(m_bits + w, MAX32);
                m_ferr    = sat(m_ferr + (w != 0), MAX32);
                m_frames4 = sat(m_frames4 + 1, MAX4);
                m_bits4   = sat(m_bits4 + w, MAX4);
                m_ferr4   = sat(m_ferr4 + (w != 0), MAX4);
                m_last    = w;
                m_pulse   = (w != 0);
            end else begin
                m_pulse = 0;
            end
            if (tx_valid && full && !pop) m_ovf = 1;
            if (rx_valid && was_empty)    m_udf = 1;
        end
    endtask

    task automatic compare_all();
        check("frame_cnt",       frame_cnt,       m_frames);
        check("bit_err_cnt",     bit_err_cnt,     m_bits);
        check("frame_err_cnt",   frame_err_cnt,   m_ferr);
        check("last_err_bits",   last_err_bits,   m_last);
        check("err_pulse",       err_pulse,       m_pulse);
        check("fifo_level",      fifo_level,      q.size());
        check("overflow",        overflow,        m_ovf);
        check("underflow",       underflow,       m_udf);
        check("sat_frame_cnt",   s_frame_cnt,     m_frames4);
        check("sat_bit_err_cnt", s_bit_err_cnt,   m_bits4);
        check("sat_frame_err",   s_frame_err_cnt, m_ferr4);
    endtask

    // Drives one cycle of inputs, advances the model at the edge and compares just after it.
    task automatic step(input logic r, input logic tv, input logic [DATA_W-1:0] td,
                        input logic rv, input logic [DATA_W-1:0] rd, input logic cl);
        rst = r; tx_valid = tv; tx_data = td; rx_valid = rv; rx_data = rd; clear = cl;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, '0, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] words[5];
        logic [DATA_W-1:0] rd, mask;

        rst = 1; tx_valid = 0; rx_valid = 0; clear = 0; tx_data = '0; rx_data = '0;
        @(negedge clk);

        // Reset
        step(1, 0, '0, 0, '0, 0);
        step(1, 0, '0, 0, '0, 0);
        idle();
        check("plan_reset_level", fifo_level, 0);
        check("plan_reset_frames", frame_cnt, 0);

        // Clean frame
        step(0, 1, 16'h147C, 0, '0, 0);
        idle();
        step(0, 0, '0, 1, 16'h147C, 0);
        check("plan_clean_frames", frame_cnt, 1);
        check("plan_clean_pulse", err_pulse, 0);
        check("plan_clean_level", fifo_level, 0);

        // Errored frames
        step(0, 0, '0, 0, '0, 1);
        step(0, 1, 16'h147C, 0, '0, 0);
        step(0, 1, 16'hFFFF, 0, '0, 0);
        step(0, 0, '0, 1, 16'h147D, 0);
        check("plan_err1_bits", last_err_bits, 1);
        check("plan_err1_pulse", err_pulse, 1);
        step(0, 0, '0, 1, 16'h0000, 0);
        check("plan_err2_bits", last_err_bits, 16);
        check("plan_err2_pulse", err_pulse, 1);
        idle();
        check("plan_pulse_drop", err_pulse, 0);
        check("plan_bit_err_total", bit_err_cnt, 17);
        check("plan_frame_err_total", frame_err_cnt, 2);
        check("plan_frame_total", frame_cnt, 2);

        // FIFO bounds: overflow, drain in order, underflow
        for (int i = 0; i < 5; i++) begin
            words[i] = DATA_W'($urandom);
            step(0, 1, words[i], 0, '0, 0);
        end
        check("plan_ovf_flag", overflow, 1);
        check("plan_ovf_level", fifo_level, 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 1, words[i], 0);
            check("plan_drain_match", last_err_bits, 0);
        end
        step(0, 0, '0, 1, 16'h1234, 0);
        check("plan_udf_flag", underflow, 1);
        check("plan_udf_frames", frame_cnt, 6);

        // Full with simultaneous tx/rx
        step(0, 0, '0, 0, '0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, DATA_W'(i), 0, '0, 0);
        step(0, 1, 16'hAAAA, 1, 16'h0000, 0);
        check("plan_full_txrx_level", fifo_level, 4);
        check("plan_full_txrx_ovf", overflow, 0);

        // Clear together with a pop
        step(0, 0, '0, 1, 16'h0003, 1);
        check("plan_clear_pop_frames", frame_cnt, 0);
        check("plan_clear_pop_level", fifo_level, 3);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 16'h5555, 0);
        step(0, 1, 16'hBEEF, 1, 16'h0000, 0);
        check("plan_empty_txrx_udf", underflow, 1);
        check("plan_empty_txrx_level", fifo_level, 1);
        step(0, 0, '0, 1, 16'hBEEF, 1);

        // Saturation of the 4-bit instance
        for (int i = 0; i < 16; i++) begin
            step(0, 1, DATA_W'(i * 7), 0, '0, 0);
            step(0, 0, '0, 1, DATA_W'(i * 7), 0);
        end
        check("plan_sat_frames", s_frame_cnt, 15);
        step(0, 1, 16'hFFFF, 0, '0, 0);
        step(0, 0, '0, 1, 16'h0000, 0);
        check("plan_sat_bits", s_bit_err_cnt, 15);
        check("plan_sat_ferr", s_frame_err_cnt, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            mask = '0;
            case ($urandom_range(0, 3))
                0: mask = '0;
                1: mask = DATA_W'(1) << $urandom_range(0, DATA_W - 1);
                2: mask = (DATA_W'(1) << $urandom_range(0, DATA_W - 1)) | (DATA_W'(1) << $urandom_range(0, DATA_W - 1));
                default: mask = DATA_W'($urandom);
            endcase
            rd = ((q.size() > 0) ? q[0] : DATA_W'($urandom)) ^ mask;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 55), DATA_W'($urandom),
                 ($urandom_range(0, 99) < 50), rd, ($urandom_range(0, 79) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ber_monitor.md
# ber_monitor

Bit/frame error-rate monitor at the tail of the link chain, downstream of the four Hamming decoders. Every transmitted 16-bit source word is queued in a small reference FIFO. Each decoded word is compared against the oldest queued word, and the monitor accumulates frame, bit-error and frame-error counts. It also reports per-frame error weight and sticky FIFO fault flags, so simulation and hardware runs can score the noisy channel without a testbench-side scoreboard.

## Interface
- DATA_W, 16: width of source/decoded word.
- DEPTH, 4: reference FIFO depth, power of two, ≥2.
- CNT_W, 32: width of each statistics counter.

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  push tx_data into reference FIFO this cycle.
- tx_data  in  DATA_W  transmitted source word.
- rx_valid  in  1  rx_data is a decoded word; pop-and-compare this cycle.
- rx_data  in  DATA_W  decoded word from Hamming decoders.
- clear  in  1  zero statistics and sticky flags; FIFO contents kept.
- frame_cnt  out  CNT_W  compared frames, saturating.
- bit_err_cnt  out  CNT_W  total mismatched bits, saturating.
- frame_err_cnt  out  CNT_W  frames with ≥1 mismatched bit, saturating.
- last_err_bits  out  $clog2(DATA_W+1)  popcount of the most recent comparison.
- err_pulse  out  1  one-cycle pulse: the last comparison had errors.
- fifo_level  out  $clog2(DEPTH)+1  entries currently queued.
- overflow  out  1  sticky: a push was dropped while full.
- underflow  out  1  sticky: an rx word arrived while the FIFO was empty.

## Operation
- FIFO: circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH. The level counter holds 0..DEPTH.
- Push: tx_valid and (not full, or a pop in the same cycle). Push while full without a pop drops tx_data and sets overflow.
- Pop: rx_valid and level>0. rx_valid at level 0 sets underflow. The rx word is discarded and no counter changes.
- No bypass: with FIFO empty, tx_valid and rx_valid in the same cycle gives an underflow, and tx_data is still pushed (level becomes 1).
- Full with tx_valid and rx_valid in the same cycle: pop and push both succeed, level stays DEPTH, no overflow.
- Compare on pop: diff = rx_data XOR head, w = popcount(diff) over 0..DATA_W.
  - frame_cnt += 1.
  - bit_err_cnt += w.
  - frame_err_cnt += (w≠0).
  - last_err_bits ← w.
  - err_pulse ← (w≠0).
- Saturation: each counter clamps at 2^CNT_W−1. If the add would exceed the limit, the result is all-ones. Counters never wrap.
- clear clears all three counters, last_err_bits, err_pulse, overflow and underflow. Pointers and level are unchanged.
- clear together with a pop: the pop still happens and clear wins, so the counters read 0 afterwards.
- clear together with an overflow or underflow event: the flag reads 0 afterwards.
- No explicit state machine. State is the pointers, level, counters and sticky flags.

## Timing
- Reset, held at least one edge: all outputs 0, pointers 0, level 0. FIFO storage is not cleared.
- rst overrides every other input, including clear, tx_valid and rx_valid.
- Reset mid-operation discards all queued entries.
- Latency: rx_valid sampled at edge N → frame_cnt, bit_err_cnt, frame_err_cnt, last_err_bits and err_pulse are valid after edge N. Outputs are registered and visible in cycle N+1.
- err_pulse is high for exactly one cycle per errored comparison. Back-to-back errored frames keep it high on consecutive cycles.
- last_err_bits holds its value until the next comparison, clear or reset.
- fifo_level and the sticky flags update on the same edge as the push or pop.
- Throughput: one push and one pop per cycle sustained.
- No combinational path from any input to any output.

## Test plan
- Reset: rst=1 for 2 cycles, then idle → all counters 0, fifo_level=0, overflow=0, underflow=0, err_pulse=0.
- Clean frame: push 0x147C. Two cycles later rx 0x147C → frame_cnt=1, bit_err_cnt=0, frame_err_cnt=0, last_err_bits=0, err_pulse stays 0, fifo_level back to 0.
- Errored frames:
  - Push 0x147C then 0xFFFF.
  - rx 0x147D → last_err_bits=1, err_pulse=1 for one cycle.
  - Next cycle rx 0x0000 → last_err_bits=16.
  - End state: bit_err_cnt=17, frame_err_cnt=2, frame_cnt=2.
- FIFO bounds (DEPTH=4):
  - Push 5 words with no rx → overflow=1, level=4. The 5th word is dropped, and the following 4 rx words match words 1..4.
  - rx on empty → underflow=1, counters unchanged.
  - Full plus simultaneous tx/rx → level stays 4, overflow not set by that cycle.
- Clear/simultaneity:
  - With counters nonzero, assert clear together with rx_valid → counters 0 afterwards, level decremented.
  - Empty FIFO with tx_valid and rx_valid together → underflow=1, level=1.
- Saturation (CNT_W=4): 15 clean frames, then 1 more → frame_cnt stays 15. One frame with 16 errors → bit_err_cnt=15, not wrapped.
